// File: rtl/uart_tx_fifo_reader.sv
// uart_tx_fifo_reader
//
// UART transmit engine that drains a first-word-fall-through FIFO and
// serialises each byte onto the tx line. Frame: 1 start bit, 8 data bits
// LSB first, an optional parity bit, 1 stop bit. One byte is popped per frame.
//
// Ports:
//   clk          - single clock
//   rst          - asynchronous, active-high reset
//   fifo_ren     - FIFO pop strobe (combinational)
//   fifo_dout    - FIFO head data, valid whenever fifo_empty_n is high
//   fifo_empty_n - FIFO holds at least one word
//   tx           - serial line, idle high (registered)
//   tx_busy      - high while a frame is on the line (registered)
//   tx_done      - one-cycle pulse in the first idle cycle after a stop bit
//
// FIFO handshake: the head word is consumed on a rising clk edge where
// fifo_ren is high; fifo_ren only rises in IDLE with fifo_empty_n high,
// and fifo_dout is captured on that same edge.
module uart_tx_fifo_reader #(
    parameter int    baud_div         = 868,
    parameter string parity_mode      = "none",
    parameter int    simulation_delay = 1
) (
    input  logic       clk,
    input  logic       rst,
    output logic       fifo_ren,
    input  logic [7:0] fifo_dout,
    input  logic       fifo_empty_n,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int               cnt_w      = $clog2(baud_div - 1) + 1;
    localparam logic [cnt_w-1:0] cnt_last   = cnt_w'(baud_div - 1);
    localparam bit               has_parity = (parity_mode != "none");
    localparam bit               odd_parity = (parity_mode == "odd");

    // simulation_delay belongs to the behavioural model of this block; the
    // synthesizable model updates its registers with zero delay. The named
    // scope below only appears in an elaborated design built with an
    // out-of-range configuration, which makes such a build easy to spot.
    if (baud_div < 2 || simulation_delay < 0) begin : g_illegal_config
    end

    typedef enum logic [2:0] {
        st_idle,
        st_start,
        st_data,
        st_parity,
        st_stop
    } state_t;

    state_t           state;
    logic [cnt_w-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic [7:0]       byte_q;
    logic             bit_end;
    logic             par_bit;

    assign bit_end  = (bit_cnt == cnt_last);
    // Parity comes from the byte as popped; shreg is destroyed by shifting.
    assign par_bit  = odd_parity ? ~^byte_q : ^byte_q;
    assign fifo_ren = (state == st_idle) & fifo_empty_n & ~rst;

    // tx is registered, so each transition loads the level of the bit that
    // the next state drives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= st_idle;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            byte_q  <= '0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                st_idle: begin
                    bit_cnt <= '0;
                    if (fifo_empty_n) begin
                        shreg   <= fifo_dout;
                        byte_q  <= fifo_dout;
                        bit_idx <= '0;
                        tx      <= 1'b0;
                        tx_busy <= 1'b1;
                        state   <= st_start;
                    end
                end
                st_start: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        tx      <= shreg[0];
                        state   <= st_data;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                st_data: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        shreg   <= shreg >> 1;
                        if (bit_idx == 3'd7) begin
                            if (has_parity) begin
                                tx    <= par_bit;
                                state <= st_parity;
                            end else begin
                                tx    <= 1'b1;
                                state <= st_stop;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                st_parity: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        tx      <= 1'b1;
                        state   <= st_stop;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                st_stop: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                        state   <= st_idle;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    bit_cnt <= '0;
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                    state   <= st_idle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Bench for uart_tx_fifo_reader. Four lanes share one clock:
//   lane 0: baud_div 4,   no parity
//   lane 1: baud_div 4,   even parity
//   lane 2: baud_div 4,   odd parity
//   lane 3: baud_div 868, no parity
// Each lane has its own FIFO model, expected-frame queue and line monitor.
module tb_uart_tx_fifo_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst          [4];
    logic       fifo_ren     [4];
    logic [7:0] fifo_dout    [4] = '{default: 8'h00};
    logic       fifo_empty_n [4] = '{default: 1'b0};
    logic       tx_line      [4];
    logic       tx_busy      [4];
    logic       tx_done      [4];

    logic [7:0]  fifo_q [4][$];
    logic [10:0] exp_q  [4][$];

    int exp_pops [4] = '{default: 0};
    int pops     [4] = '{default: 0};
    int exp_done [4] = '{default: 0};
    int dones    [4] = '{default: 0};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Reference frame: bit i of the result is the line level during bit
    // period i (start, d0..d7, [parity], stop).
    function automatic logic [10:0] frame_of(input int g, input logic [7:0] b);
        logic [10:0] f;
        int          ones;
        f    = '0;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = b[i];
            ones   = ones + int'(b[i]);
        end
        if (g == 1) begin
            f[9]  = (ones % 2 == 1);
            f[10] = 1'b1;
        end else if (g == 2) begin
            f[9]  = (ones % 2 == 0);
            f[10] = 1'b1;
        end else begin
            f[9] = 1'b1;
        end
        return f;
    endfunction

    task automatic push(input int g, input logic [7:0] b);
        fifo_q[g].push_back(b);
        exp_q[g].push_back(frame_of(g, b));
        exp_pops[g]++;
        exp_done[g]++;
    endtask

    task automatic wait_drain(input int g, input int budget);
        int n;
        n = 0;
        while ((exp_q[g].size() != 0 || fifo_q[g].size() != 0 || tx_busy[g] !== 1'b0)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(n < budget, $sformatf("lane%0d drain timeout", g), n, budget);
        repeat (3) @(negedge clk);
    endtask

    task automatic end_counts(input int g);
        check(pops[g] == exp_pops[g], $sformatf("lane%0d pop count", g), pops[g], exp_pops[g]);
        check(dones[g] == exp_done[g], $sformatf("lane%0d tx_done count", g), dones[g], exp_done[g]);
    endtask

    for (genvar g = 0; g < 4; g++) begin : g_lane
        localparam int    bd = (g == 3) ? 868 : 4;
        localparam int    nb = (g == 1 || g == 2) ? 11 : 10;
        localparam string pm = (g == 1) ? "even" : ((g == 2) ? "odd" : "none");

        uart_tx_fifo_reader #(
            .baud_div(bd),
            .parity_mode(pm),
            .simulation_delay(1)
        ) u_dut (
            .clk(clk),
            .rst(rst[g]),
            .fifo_ren(fifo_ren[g]),
            .fifo_dout(fifo_dout[g]),
            .fifo_empty_n(fifo_empty_n[g]),
            .tx(tx_line[g]),
            .tx_busy(tx_busy[g]),
            .tx_done(tx_done[g])
        );

        // FWFT FIFO model: pops on an edge where fifo_ren is high.
        always @(posedge clk) begin
            if (fifo_ren[g] === 1'b1) begin
                pops[g]++;
                check(fifo_q[g].size() != 0, $sformatf("lane%0d pop from empty fifo", g),
                      fifo_q[g].size(), 1);
                if (fifo_q[g].size() != 0) void'(fifo_q[g].pop_front());
            end
            fifo_empty_n[g] <= (fifo_q[g].size() != 0);
            if (fifo_q[g].size() != 0) fifo_dout[g] <= fifo_q[g][0];
        end

        always @(negedge clk) begin
            if (tx_done[g] === 1'b1) dones[g]++;
        end

        bit exp_start = 1'b0;

        // Line monitor: samples tx once per cycle, rebuilds the frame, checks
        // every bit is steady for bd cycles, then checks the done pulse.
        always begin : mon
            logic [10:0] got;
            logic [10:0] want;
            bit          steady;
            bit          aborted;
            @(negedge clk);
            if (exp_start) begin
                exp_start = 1'b0;
                check(tx_line[g] === 1'b0, $sformatf("lane%0d one-cycle inter-frame gap", g),
                      tx_line[g], 0);
            end
            if (rst[g] === 1'b0 && tx_line[g] === 1'b0) begin
                got     = '0;
                steady  = 1'b1;
                aborted = 1'b0;
                for (int i = 0; i < nb * bd; i++) begin
                    if (i > 0) @(negedge clk);
                    if (rst[g] !== 1'b0) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (i % bd == 0) got[i / bd] = tx_line[g];
                    else if (tx_line[g] !== got[i / bd]) steady = 1'b0;
                    if (tx_busy[g] !== 1'b1) steady = 1'b0;
                end
                if (!aborted) begin
                    if (exp_q[g].size() == 0) begin
                        check(1'b0, $sformatf("lane%0d unexpected frame", g), got, 0);
                    end else begin
                        want = exp_q[g].pop_front();
                        check(got[nb-1:0] == want[nb-1:0], $sformatf("lane%0d frame bits", g),
                              got, want);
                    end
                    check(steady, $sformatf("lane%0d bit width/busy", g), steady, 1);
                    @(negedge clk);
                    check(tx_done[g] === 1'b1 && tx_busy[g] === 1'b0 && tx_line[g] === 1'b1,
                          $sformatf("lane%0d end of frame {done,busy,tx}", g),
                          {tx_done[g], tx_busy[g], tx_line[g]}, 3'b101);
                    if (fifo_empty_n[g] === 1'b1) exp_start = 1'b1;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int viol;
        for (int g = 0; g < 4; g++) rst[g] = 1'b1;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 4; g++)
            check(tx_line[g] === 1'b1 && tx_busy[g] === 1'b0 && tx_done[g] === 1'b0 &&
                  fifo_ren[g] === 1'b0, $sformatf("lane%0d reset {tx,busy,done,ren}", g),
                  {tx_line[g], tx_busy[g], tx_done[g], fifo_ren[g]}, 4'b1000);
        for (int g = 0; g < 4; g++) rst[g] = 1'b0;

        // Empty FIFO: nothing may move.
        viol = 0;
        repeat (100) begin
            @(negedge clk);
            if (fifo_ren[0] !== 1'b0 || tx_line[0] !== 1'b1 || tx_busy[0] !== 1'b0 ||
                tx_done[0] !== 1'b0) viol++;
        end
        check(viol == 0, "empty fifo idle cycles violated", viol, 0);

        // Single byte, then a back-to-back burst.
        push(0, 8'hA5);
        wait_drain(0, 200);
        end_counts(0);
        push(0, 8'h00);
        push(0, 8'hFF);
        push(0, 8'h55);
        wait_drain(0, 400);
        end_counts(0);

        // Parity lanes.
        push(1, 8'h07);
        push(2, 8'h07);
        push(2, 8'h00);
        wait_drain(1, 200);
        wait_drain(2, 300);
        end_counts(1);
        end_counts(2);

        // Random bytes with random gaps on the short-divisor lanes.
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < 3; g++) push(g, 8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 60)) @(negedge clk);
        end
        for (int g = 0; g < 3; g++) begin
            wait_drain(g, 3000);
            end_counts(g);
        end

        // Reset in the middle of data bit 3; the popped byte is lost.
        push(0, 8'($urandom_range(0, 255)));
        push(0, 8'($urandom_range(0, 255)));
        n = 0;
        while (tx_line[0] !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(n < 100, "lane0 start bit before reset timeout", n, 100);
        repeat (17) @(negedge clk);
        rst[0] = 1'b1;
        #1;
        check(tx_line[0] === 1'b1 && tx_busy[0] === 1'b0 && tx_done[0] === 1'b0,
              "async reset {tx,busy,done}", {tx_line[0], tx_busy[0], tx_done[0]}, 3'b100);
        void'(exp_q[0].pop_front());
        exp_done[0]--;
        repeat (3) @(negedge clk);
        rst[0] = 1'b0;
        #1;
        check(fifo_ren[0] === 1'b1, "fifo_ren right after reset release", fifo_ren[0], 1);
        wait_drain(0, 200);
        end_counts(0);

        // Large divisor.
        push(3, 8'($urandom_range(0, 255)));
        push(3, 8'($urandom_range(0, 255)));
        wait_drain(3, 20000);
        end_counts(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
